cp0_exception_ctrl: RTL and testbench

Coprocessor-0 exception controller: holds Status, Cause, EPC, BadVAddr and optional Count/Compare, and decides each cycle whether the instruction in MEM takes an exception or an interrupt. It drives the answer-exception, cause and EPC signals consumed by next-PC selection and by the pipeline flush logic. It also serves mfc0 reads and commits mtc0 writes and eret from MEM.

---
 rtl/cp0_exception_ctrl_pkg.sv | 31 +++
 rtl/cp0_timer.sv | 47 ++++
 rtl/cp0_exception_ctrl.sv | 130 +++++++++++++
 tb/tb_cp0_exception_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_exception_ctrl_pkg.sv
// Shared CP0 definitions: cause codes, handler entries, register numbers and bit positions.
// Used by cp0_exception_ctrl and cp0_timer (timer only built with CP0_TIMER_EN).
package cp0_exception_ctrl_pkg;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;
   localparam logic [4:0] EXC_TRAP = 5'd13;

   localparam logic [31:0] INT_HANDLER_ENTRY = 32'hBFC0_0380;
   localparam logic [31:0] EXC_HANDLER_ENTRY = 32'hBFC0_0380;

   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   localparam int STATUS_IE_BIT     = 0;
   localparam int STATUS_EXL_BIT    = 1;
   localparam int STATUS_IM_LO      = 8;
   localparam int CAUSE_EXCCODE_LO  = 2;
   localparam int CAUSE_IP_LO       = 8;
   localparam int CAUSE_BD_BIT      = 31;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle, a Count==Compare match
// latches the timer interrupt until Compare is rewritten. Built only with CP0_TIMER_EN.
module cp0_timer
   import cp0_exception_ctrl_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_we,
   input  logic [4:0]  i_waddr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_count,
   output logic [31:0] o_compare,
   output logic        o_timer_int
);

   logic        tick_q;
   logic [31:0] count_q;
   logic [31:0] compare_q;
   logic        timer_int_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         tick_q      <= 1'b0;
         count_q     <= '0;
         compare_q   <= '0;
         timer_int_q <= 1'b0;
      end else begin
         tick_q <= ~tick_q;
         if (i_we && i_waddr == CP0_COUNT)
            count_q <= i_wdata;
         else if (tick_q)
            count_q <= count_q + 32'd1;
         // A Compare write acknowledges the timer interrupt and wins over a same-cycle match.
         if (i_we && i_waddr == CP0_COMPARE) begin
            compare_q   <= i_wdata;
            timer_int_q <= 1'b0;
         end else if (compare_q != '0 && count_q == compare_q) begin
            timer_int_q <= 1'b1;
         end
      end
   end

   assign o_count     = count_q;
   assign o_compare   = compare_q;
   assign o_timer_int = timer_int_q;

endmodule

// File: rtl/cp0_exception_ctrl.sv
// CP0 exception controller: Status/Cause/EPC/BadVAddr, interrupt/exception answer for MEM,
// mfc0/mtc0/eret. Define CP0_TIMER_EN to add Count/Compare and the IP[7] timer interrupt.
module cp0_exception_ctrl
   import cp0_exception_ctrl_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_MEM_valid,
   input  logic [31:0] i_MEM_pc,
   input  logic        i_MEM_in_delay_slot,
   input  logic        i_MEM_exc_valid,
   input  logic [4:0]  i_MEM_exc_cause,
   input  logic [31:0] i_MEM_bad_vaddr,
   input  logic        i_MEM_is_eret,
   input  logic        i_MEM_cp0_we,
   input  logic [4:0]  i_MEM_cp0_waddr,
   input  logic [31:0] i_MEM_cp0_wdata,
   input  logic [4:0]  i_cp0_raddr,
   input  logic [5:0]  i_hw_int,
   output logic [31:0] o_cp0_rdata,
   output logic        o_answer_exc,
   output logic [4:0]  o_exception_cause,
   output logic [31:0] o_epc_value,
   output logic        o_flush
);

   logic [7:0]  status_im_q;
   logic        status_exl_q;
   logic        status_ie_q;
   logic        cause_bd_q;
   logic [1:0]  cause_ip_sw_q;
   logic [4:0]  cause_exc_q;
   logic [31:0] epc_q;
   logic [31:0] badvaddr_q;
   logic [5:0]  hw_sync1_q;
   logic [5:0]  hw_sync2_q;

   logic [31:0] count;
   logic [31:0] compare;
   logic        timer_int;
   logic [7:0]  cause_ip;
   logic        int_pending;
   logic        answer;
   logic [4:0]  cause_sel;
   logic        eret_commit;
   logic        mtc0_commit;

`ifdef CP0_TIMER_EN
   cp0_timer u_timer (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_we        (mtc0_commit),
      .i_waddr     (i_MEM_cp0_waddr),
      .i_wdata     (i_MEM_cp0_wdata),
      .o_count     (count),
      .o_compare   (compare),
      .o_timer_int (timer_int)
   );
`else
   assign count     = '0;
   assign compare   = '0;
   assign timer_int = 1'b0;
`endif

   assign cause_ip    = {hw_sync2_q[5] | timer_int, hw_sync2_q[4:0], cause_ip_sw_q};
   assign int_pending = (|(cause_ip & status_im_q)) & status_ie_q & ~status_exl_q;
   assign answer      = i_MEM_valid & (int_pending | i_MEM_exc_valid);
   assign cause_sel   = int_pending ? EXC_INT : i_MEM_exc_cause;
   assign eret_commit = i_MEM_valid & i_MEM_is_eret & ~answer;
   assign mtc0_commit = i_MEM_valid & i_MEM_cp0_we & ~answer & ~i_MEM_is_eret;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         status_im_q   <= '0;
         status_exl_q  <= 1'b0;
         status_ie_q   <= 1'b0;
         cause_bd_q    <= 1'b0;
         cause_ip_sw_q <= '0;
         cause_exc_q   <= '0;
         epc_q         <= '0;
         badvaddr_q    <= '0;
         hw_sync1_q    <= '0;
         hw_sync2_q    <= '0;
      end else begin
         hw_sync1_q <= i_hw_int;
         hw_sync2_q <= hw_sync1_q;
         if (answer) begin
            epc_q        <= i_MEM_in_delay_slot ? i_MEM_pc - 32'd4 : i_MEM_pc;
            cause_bd_q   <= i_MEM_in_delay_slot;
            cause_exc_q  <= cause_sel;
            status_exl_q <= 1'b1;
            if (!int_pending && (i_MEM_exc_cause == EXC_ADEL || i_MEM_exc_cause == EXC_ADES))
               badvaddr_q <= i_MEM_bad_vaddr;
         end else if (eret_commit) begin
            status_exl_q <= 1'b0;
         end else if (mtc0_commit) begin
            case (i_MEM_cp0_waddr)
               CP0_STATUS: begin
                  status_im_q  <= i_MEM_cp0_wdata[STATUS_IM_LO +: 8];
                  status_exl_q <= i_MEM_cp0_wdata[STATUS_EXL_BIT];
                  status_ie_q  <= i_MEM_cp0_wdata[STATUS_IE_BIT];
               end
               CP0_CAUSE: cause_ip_sw_q <= i_MEM_cp0_wdata[CAUSE_IP_LO +: 2];
               CP0_EPC:   epc_q         <= i_MEM_cp0_wdata;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      o_cp0_rdata = '0;
      case (i_cp0_raddr)
         CP0_BADVADDR: o_cp0_rdata = badvaddr_q;
         CP0_COUNT:    o_cp0_rdata = count;
         CP0_COMPARE:  o_cp0_rdata = compare;
         CP0_STATUS:   o_cp0_rdata = {16'd0, status_im_q, 6'd0, status_exl_q, status_ie_q};
         CP0_CAUSE:    o_cp0_rdata = {cause_bd_q, 15'd0, cause_ip, 1'b0, cause_exc_q, 2'd0};
         CP0_EPC:      o_cp0_rdata = epc_q;
         default:      o_cp0_rdata = '0;
      endcase
   end

   // Outputs are forced quiet while reset is held, even before the first reset edge.
   assign o_answer_exc      = i_rst_n & answer;
   assign o_exception_cause = i_rst_n ? cause_sel : 5'd0;
   assign o_epc_value       = i_rst_n ? epc_q : 32'd0;
   assign o_flush           = i_rst_n & (answer | (i_MEM_valid & i_MEM_is_eret));

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Directed bench for cp0_exception_ctrl; timer scenario runs only with CP0_TIMER_EN.
module tb_cp0_exception_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [31:0] pc;
   logic        ds;
   logic        exc_valid;
   logic [4:0]  exc_cause;
   logic [31:0] bad;
   logic        eret;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr;
   logic [5:0]  hw_int;
   logic [31:0] rdata;
   logic        answer;
   logic [4:0]  cause;
   logic [31:0] epc;
   logic        flush;

   int passed = 0;
   int total  = 0;

   cp0_exception_ctrl dut (
      .i_clk               (clk),
      .i_rst_n             (rst_n),
      .i_MEM_valid         (valid),
      .i_MEM_pc            (pc),
      .i_MEM_in_delay_slot (ds),
      .i_MEM_exc_valid     (exc_valid),
      .i_MEM_exc_cause     (exc_cause),
      .i_MEM_bad_vaddr     (bad),
      .i_MEM_is_eret       (eret),
      .i_MEM_cp0_we        (we),
      .i_MEM_cp0_waddr     (waddr),
      .i_MEM_cp0_wdata     (wdata),
      .i_cp0_raddr         (raddr),
      .i_hw_int            (hw_int),
      .o_cp0_rdata         (rdata),
      .o_answer_exc        (answer),
      .o_exception_cause   (cause),
      .o_epc_value         (epc),
      .o_flush             (flush)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_mem;
      valid = 0; pc = 0; ds = 0; exc_valid = 0; exc_cause = 0; bad = 0;
      eret = 0; we = 0; waddr = 0; wdata = 0;
   endtask

   task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
      idle_mem();
      valid = 1; pc = 32'h0040_0500; we = 1; waddr = a; wdata = d;
      tick();
      idle_mem();
   endtask

   task automatic read_cp0(input logic [4:0] a, output logic [31:0] d);
      raddr = a;
      #1;
      d = rdata;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      rst_n = 0; hw_int = 0; raddr = 0;
      idle_mem();
      valid = 1; exc_valid = 1; exc_cause = 5'd12; pc = 32'h0040_0000;
      #1;
      total++; if (answer !== 1'b0) $display("FAIL reset_answer got %b want 0", answer); else passed++;
      total++; if (flush !== 1'b0) $display("FAIL reset_flush got %b want 0", flush); else passed++;
      total++; if (cause !== 5'd0) $display("FAIL reset_cause got %0d want 0", cause); else passed++;
      total++; if (epc !== 32'd0) $display("FAIL reset_epc got %h want 0", epc); else passed++;
      tick(); tick();
      read_cp0(5'd12, d);
      total++; if (d !== 32'd0) $display("FAIL reset_status got %h want 0", d); else passed++;
      read_cp0(5'd13, d);
      total++; if (d !== 32'd0) $display("FAIL reset_cause_reg got %h want 0", d); else passed++;
      idle_mem();
      rst_n = 1;
      tick();
   endtask

   task automatic test_overflow;
      logic [31:0] d;
      idle_mem();
      valid = 1; pc = 32'h0040_0010; exc_valid = 1; exc_cause = 5'd12;
      #1;
      total++; if (answer !== 1'b1) $display("FAIL ov_answer got %b want 1", answer); else passed++;
      total++; if (cause !== 5'd12) $display("FAIL ov_cause got %0d want 12", cause); else passed++;
      total++; if (flush !== 1'b1) $display("FAIL ov_flush got %b want 1", flush); else passed++;
      tick();
      idle_mem();
      read_cp0(5'd14, d);
      total++; if (d !== 32'h0040_0010) $display("FAIL ov_epc got %h want 00400010", d); else passed++;
      total++; if (epc !== 32'h0040_0010) $display("FAIL ov_epc_out got %h want 00400010", epc); else passed++;
      read_cp0(5'd12, d);
      total++; if (d !== 32'h0000_0002) $display("FAIL ov_status got %h want 00000002", d); else passed++;
      read_cp0(5'd13, d);
      total++; if (d !== 32'h0000_0030) $display("FAIL ov_cause_reg got %h want 00000030", d); else passed++;
   endtask

   task automatic test_delay_slot_adel;
      logic [31:0] d;
      tick();
      idle_mem();
      valid = 1; pc = 32'h0040_0024; ds = 1; exc_valid = 1; exc_cause = 5'd4; bad = 32'h0000_0003;
      #1;
      total++; if (answer !== 1'b1 || cause !== 5'd4)
         $display("FAIL adel_answer got %b/%0d want 1/4", answer, cause); else passed++;
      tick();
      idle_mem();
      read_cp0(5'd14, d);
      total++; if (d !== 32'h0040_0020) $display("FAIL adel_epc got %h want 00400020", d); else passed++;
      read_cp0(5'd13, d);
      total++; if (d !== 32'h8000_0010) $display("FAIL adel_cause_reg got %h want 80000010", d); else passed++;
      read_cp0(5'd8, d);
      total++; if (d !== 32'h0000_0003) $display("FAIL adel_badvaddr got %h want 00000003", d); else passed++;
   endtask

   task automatic test_eret;
      logic [31:0] d;
      do_mtc0(5'd14, 32'h0040_0100);
      valid = 1; pc = 32'h0040_0600; eret = 1;
      #1;
      total++; if (flush !== 1'b1) $display("FAIL eret_flush got %b want 1", flush); else passed++;
      total++; if (answer !== 1'b0) $display("FAIL eret_answer got %b want 0", answer); else passed++;
      total++; if (epc !== 32'h0040_0100) $display("FAIL eret_epc got %h want 00400100", epc); else passed++;
      tick();
      idle_mem();
      read_cp0(5'd12, d);
      total++; if (d !== 32'h0000_0000) $display("FAIL eret_status got %h want 00000000", d); else passed++;
   endtask

   task automatic test_hw_int;
      logic [31:0] d;
      do_mtc0(5'd12, 32'h0000_0401);
      read_cp0(5'd12, d);
      total++; if (d !== 32'h0000_0401) $display("FAIL hw_status got %h want 00000401", d); else passed++;
      valid = 1; pc = 32'h0040_0200; hw_int = 6'b000001;
      #1;
      total++; if (answer !== 1'b0) $display("FAIL hw_cycle1 got %b want 0", answer); else passed++;
      tick();
      hw_int = 6'b0;
      #1;
      total++; if (answer !== 1'b0) $display("FAIL hw_cycle2 got %b want 0", answer); else passed++;
      tick();
      total++; if (answer !== 1'b1 || cause !== 5'd0)
         $display("FAIL hw_cycle3 got %b/%0d want 1/0", answer, cause); else passed++;
      tick();
      idle_mem();
      read_cp0(5'd14, d);
      total++; if (d !== 32'h0040_0200) $display("FAIL hw_epc got %h want 00400200", d); else passed++;
      read_cp0(5'd12, d);
      total++; if (d !== 32'h0000_0403) $display("FAIL hw_status_exl got %h want 00000403", d); else passed++;
      // With EXL set, a steady interrupt must not be answered.
      hw_int = 6'b000001; valid = 1; pc = 32'h0040_0204;
      tick(); tick(); tick();
      total++; if (answer !== 1'b0) $display("FAIL hw_exl_block got %b want 0", answer); else passed++;
      read_cp0(5'd13, d);
      total++; if (d !== 32'h0000_0400) $display("FAIL hw_ip2 got %h want 00000400", d); else passed++;
      do_mtc0(5'd12, 32'h0000_0400);
      valid = 1; pc = 32'h0040_0208;
      #1;
      total++; if (answer !== 1'b0) $display("FAIL hw_ie_off got %b want 0", answer); else passed++;
      idle_mem();
   endtask

   task automatic test_int_vs_mtc0;
      logic [31:0] d;
      do_mtc0(5'd12, 32'h0000_0401);
      #1;
      total++; if (answer !== 1'b0) $display("FAIL hold_invalid got %b want 0", answer); else passed++;
      tick();
      valid = 1; pc = 32'h0040_0300; we = 1; waddr = 5'd14; wdata = 32'h0000_1234;
      exc_valid = 1; exc_cause = 5'd12;
      #1;
      total++; if (answer !== 1'b1 || cause !== 5'd0)
         $display("FAIL int_vs_mtc0 got %b/%0d want 1/0", answer, cause); else passed++;
      tick();
      idle_mem();
      hw_int = 6'b0;
      read_cp0(5'd14, d);
      total++; if (d !== 32'h0040_0300) $display("FAIL int_vs_mtc0_epc got %h want 00400300", d); else passed++;
      read_cp0(5'd12, d);
      total++; if (d !== 32'h0000_0403) $display("FAIL int_vs_mtc0_status got %h want 00000403", d); else passed++;
      tick(); tick(); tick();
   endtask

`ifdef CP0_TIMER_EN
   task automatic test_timer;
      logic [31:0] d;
      logic        seen;
      seen = 1'b0;
      do_mtc0(5'd11, 32'd4);
      do_mtc0(5'd9, 32'd0);
      do_mtc0(5'd12, 32'h0000_8001);
      for (int i = 0; i < 40 && !seen; i++) begin
         read_cp0(5'd13, d);
         if (d[15]) seen = 1'b1;
         else tick();
      end
      total++; if (seen !== 1'b1) $display("FAIL timer_ip7 got %b want 1", seen); else passed++;
      valid = 1; pc = 32'h0040_0400;
      #1;
      total++; if (answer !== 1'b1 || cause !== 5'd0)
         $display("FAIL timer_answer got %b/%0d want 1/0", answer, cause); else passed++;
      tick();
      do_mtc0(5'd11, 32'd0);
      read_cp0(5'd13, d);
      total++; if (d[15] !== 1'b0) $display("FAIL timer_clear got %b want 0", d[15]); else passed++;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_overflow();
      test_delay_slot_adel();
      test_eret();
      test_hw_int();
      test_int_vs_mtc0();
`ifdef CP0_TIMER_EN
      test_timer();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
